// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared sizes and grant encoding for the rename sequencer
package rename_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int PHYS_W        = 6;
  localparam int ARCH_W        = 5;
  localparam int CNT_W         = 7;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ISSUE,
    GNT_RETIRE
  } grant_e;

endpackage

// File: rtl/retire_fifo.sv
// rtl/retire_fifo.sv - synchronous FIFO buffering retired physical tags
module retire_fifo
  import rename_pkg::*;
#(
  parameter int WIDTH = PHYS_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rename_sequencer.sv
// rtl/rename_sequencer.sv - arbitrates the single-ported rename unit between issue and retire
module rename_sequencer
  import rename_pkg::*;
#(
  parameter int RET_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              ret_valid,
  output logic              ret_ready,
  input  logic [5:0]        ret_phys_reg,
  output logic              rn_issue_valid,
  output logic              rn_retire_valid,
  output logic [4:0]        rn_rs1,
  output logic [4:0]        rn_rs2,
  output logic [4:0]        rn_rd,
  output logic [5:0]        rn_retire_phys_reg,
  input  logic [5:0]        rn_phys_rd,
  input  logic [5:0]        rn_phys_rs1,
  input  logic [5:0]        rn_phys_rs2,
  input  logic [5:0]        rn_old_phys_rd,
  input  logic [4:0]        rn_arch_reg,
  output logic              out_valid,
  output logic [5:0]        out_phys_rd,
  output logic [5:0]        out_phys_rs1,
  output logic [5:0]        out_phys_rs2,
  output logic [5:0]        out_old_phys_rd,
  output logic [4:0]        out_rd,
  output logic              ret_done_valid,
  output logic [4:0]        ret_done_arch_reg,
  output logic [6:0]        free_count,
  output logic [15:0]       stall_cycles,
  output logic              err_overflow
);

  localparam logic [CNT_W-1:0] FREE_INIT = CNT_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);

  logic [PHYS_W-1:0]              fifo_head;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [$clog2(RET_FIFO_DEPTH):0] fifo_count;

  grant_e            gnt;
  grant_e            last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  free_count_q, free_count_d;
  logic [15:0]       stall_cycles_q, stall_cycles_d;
  logic              err_overflow_q, err_overflow_d;
  logic              out_valid_q, out_valid_d;
  logic [5:0]        out_phys_rd_q, out_phys_rd_d;
  logic [5:0]        out_phys_rs1_q, out_phys_rs1_d;
  logic [5:0]        out_phys_rs2_q, out_phys_rs2_d;
  logic [5:0]        out_old_phys_rd_q, out_old_phys_rd_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic              ret_done_valid_q, ret_done_valid_d;
  logic [4:0]        ret_done_arch_reg_q, ret_done_arch_reg_d;
  logic              issue_elig;
  logic              retire_elig;

  retire_fifo #(
    .WIDTH (PHYS_W),
    .DEPTH (RET_FIFO_DEPTH)
  ) u_retire_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (ret_valid),
    .push_data (ret_phys_reg),
    .pop       (gnt == GNT_RETIRE),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ret_ready   = !fifo_full;
  assign issue_elig  = dec_valid && (free_count_q != '0);
  assign retire_elig = !fifo_empty;

  // A full FIFO or an exhausted free list forces retire so the ROB can never deadlock issue.
  always_comb begin
    gnt = GNT_NONE;
    if (reset) begin
      gnt = GNT_NONE;
    end else if (fifo_full || ((free_count_q == '0) && retire_elig)) begin
      gnt = GNT_RETIRE;
    end else if (issue_elig && retire_elig) begin
      gnt = (last_grant_q == GNT_ISSUE) ? GNT_RETIRE : GNT_ISSUE;
    end else if (issue_elig) begin
      gnt = GNT_ISSUE;
    end else if (retire_elig) begin
      gnt = GNT_RETIRE;
    end
  end

  assign dec_ready          = (gnt == GNT_ISSUE);
  assign rn_issue_valid     = (gnt == GNT_ISSUE);
  assign rn_retire_valid    = (gnt == GNT_RETIRE);
  assign rn_rs1             = (gnt == GNT_ISSUE)  ? dec_rs1   : '0;
  assign rn_rs2             = (gnt == GNT_ISSUE)  ? dec_rs2   : '0;
  assign rn_rd              = (gnt == GNT_ISSUE)  ? dec_rd    : '0;
  assign rn_retire_phys_reg = (gnt == GNT_RETIRE) ? fifo_head : '0;

  always_comb begin
    last_grant_d        = last_grant_q;
    free_count_d        = free_count_q;
    stall_cycles_d      = stall_cycles_q;
    err_overflow_d      = err_overflow_q;
    out_valid_d         = (gnt == GNT_ISSUE);
    out_phys_rd_d       = out_phys_rd_q;
    out_phys_rs1_d      = out_phys_rs1_q;
    out_phys_rs2_d      = out_phys_rs2_q;
    out_old_phys_rd_d   = out_old_phys_rd_q;
    out_rd_d            = out_rd_q;
    ret_done_valid_d    = (gnt == GNT_RETIRE);
    ret_done_arch_reg_d = ret_done_arch_reg_q;

    if (gnt != GNT_NONE) begin
      last_grant_d = gnt;
    end
    if (gnt == GNT_ISSUE) begin
      free_count_d      = free_count_q - CNT_W'(1);
      out_phys_rd_d     = rn_phys_rd;
      out_phys_rs1_d    = rn_phys_rs1;
      out_phys_rs2_d    = rn_phys_rs2;
      out_old_phys_rd_d = rn_old_phys_rd;
      out_rd_d          = dec_rd;
    end
    if (gnt == GNT_RETIRE) begin
      ret_done_arch_reg_d = rn_arch_reg;
      if (free_count_q == FREE_INIT) begin
        err_overflow_d = 1'b1;
      end else begin
        free_count_d = free_count_q + CNT_W'(1);
      end
    end
    if (dec_valid && (free_count_q == '0) && (stall_cycles_q != 16'hffff)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q        <= GNT_RETIRE;
      free_count_q        <= FREE_INIT;
      stall_cycles_q      <= '0;
      err_overflow_q      <= 1'b0;
      out_valid_q         <= 1'b0;
      out_phys_rd_q       <= '0;
      out_phys_rs1_q      <= '0;
      out_phys_rs2_q      <= '0;
      out_old_phys_rd_q   <= '0;
      out_rd_q            <= '0;
      ret_done_valid_q    <= 1'b0;
      ret_done_arch_reg_q <= '0;
    end else begin
      last_grant_q        <= last_grant_d;
      free_count_q        <= free_count_d;
      stall_cycles_q      <= stall_cycles_d;
      err_overflow_q      <= err_overflow_d;
      out_valid_q         <= out_valid_d;
      out_phys_rd_q       <= out_phys_rd_d;
      out_phys_rs1_q      <= out_phys_rs1_d;
      out_phys_rs2_q      <= out_phys_rs2_d;
      out_old_phys_rd_q   <= out_old_phys_rd_d;
      out_rd_q            <= out_rd_d;
      ret_done_valid_q    <= ret_done_valid_d;
      ret_done_arch_reg_q <= ret_done_arch_reg_d;
    end
  end

  assign free_count        = free_count_q;
  assign stall_cycles      = stall_cycles_q;
  assign err_overflow      = err_overflow_q;
  assign out_valid         = out_valid_q;
  assign out_phys_rd       = out_phys_rd_q;
  assign out_phys_rs1      = out_phys_rs1_q;
  assign out_phys_rs2      = out_phys_rs2_q;
  assign out_old_phys_rd   = out_old_phys_rd_q;
  assign out_rd            = out_rd_q;
  assign ret_done_valid    = ret_done_valid_q;
  assign ret_done_arch_reg = ret_done_arch_reg_q;

endmodule

// File: tb/tb_rename_sequencer.sv
// tb/tb_rename_sequencer.sv - directed self-checking bench for rename_sequencer
module tb_rename_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid;
  logic       dec_ready;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       ret_valid;
  logic       ret_ready;
  logic [5:0] ret_phys_reg;
  logic       rn_issue_valid, rn_retire_valid;
  logic [4:0] rn_rs1, rn_rs2, rn_rd;
  logic [5:0] rn_retire_phys_reg;
  logic [5:0] rn_phys_rd, rn_phys_rs1, rn_phys_rs2, rn_old_phys_rd;
  logic [4:0] rn_arch_reg;
  logic       out_valid;
  logic [5:0] out_phys_rd, out_phys_rs1, out_phys_rs2, out_old_phys_rd;
  logic [4:0] out_rd;
  logic       ret_done_valid;
  logic [4:0] ret_done_arch_reg;
  logic [6:0] free_count;
  logic [15:0] stall_cycles;
  logic       err_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in rename unit: results are simple functions of the fields it is driven with.
  assign rn_phys_rd     = {1'b1, rn_rd};
  assign rn_phys_rs1    = {1'b0, rn_rs1};
  assign rn_phys_rs2    = {1'b0, rn_rs2} + 6'd8;
  assign rn_old_phys_rd = {1'b0, rn_rd};
  assign rn_arch_reg    = rn_retire_phys_reg[4:0] ^ 5'h1f;

  rename_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .dec_valid          (dec_valid),
    .dec_ready          (dec_ready),
    .dec_rs1            (dec_rs1),
    .dec_rs2            (dec_rs2),
    .dec_rd             (dec_rd),
    .ret_valid          (ret_valid),
    .ret_ready          (ret_ready),
    .ret_phys_reg       (ret_phys_reg),
    .rn_issue_valid     (rn_issue_valid),
    .rn_retire_valid    (rn_retire_valid),
    .rn_rs1             (rn_rs1),
    .rn_rs2             (rn_rs2),
    .rn_rd              (rn_rd),
    .rn_retire_phys_reg (rn_retire_phys_reg),
    .rn_phys_rd         (rn_phys_rd),
    .rn_phys_rs1        (rn_phys_rs1),
    .rn_phys_rs2        (rn_phys_rs2),
    .rn_old_phys_rd     (rn_old_phys_rd),
    .rn_arch_reg        (rn_arch_reg),
    .out_valid          (out_valid),
    .out_phys_rd        (out_phys_rd),
    .out_phys_rs1       (out_phys_rs1),
    .out_phys_rs2       (out_phys_rs2),
    .out_old_phys_rd    (out_old_phys_rd),
    .out_rd             (out_rd),
    .ret_done_valid     (ret_done_valid),
    .ret_done_arch_reg  (ret_done_arch_reg),
    .free_count         (free_count),
    .stall_cycles       (stall_cycles),
    .err_overflow       (err_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic tick(input logic rst, input logic dv, input logic rv,
                      input logic [5:0] tag, input logic [4:0] rd);
    @(negedge clk);
    reset        = rst;
    dec_valid    = dv;
    ret_valid    = rv;
    ret_phys_reg = tag;
    dec_rd       = rd;
    #1;
  endtask

  int t4_dv   [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
  int t4_rv   [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int t4_tag  [13] = '{10, 11, 12, 13, 14, 15, 16, 20, 0, 0, 0, 0, 0};
  int t4_gnt  [13] = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 2, 2, 0};
  int t4_rdy  [13] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
  int t4_head [13] = '{0, 10, 0, 11, 0, 12, 0, 13, 0, 14, 15, 16, 0};

  initial begin
    reset = 1'b1; dec_valid = 1'b0; ret_valid = 1'b0; ret_phys_reg = '0;
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = '0;

    // reset behaviour
    tick(1, 1, 0, 0, 5);
    check("rst_dec_ready", dec_ready, 0);
    check("rst_rn_issue", rn_issue_valid, 0);
    tick(0, 0, 0, 0, 0);
    check("rst_free", free_count, 32);
    check("rst_out_valid", out_valid, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_err", err_overflow, 0);
    check("rst_ret_ready", ret_ready, 1);
    check("rst_ret_done", ret_done_valid, 0);

    // three back-to-back issues
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, 5);
      check("t1_dec_ready", dec_ready, 1);
      check("t1_rn_rd", rn_rd, 5);
      if (i > 0) check("t1_out_valid", out_valid, 1);
    end
    tick(0, 0, 0, 0, 0);
    check("t1_out_valid_last", out_valid, 1);
    check("t1_out_phys_rd", out_phys_rd, 37);
    check("t1_out_phys_rs1", out_phys_rs1, 1);
    check("t1_out_phys_rs2", out_phys_rs2, 10);
    check("t1_out_old", out_old_phys_rd, 5);
    check("t1_out_rd", out_rd, 5);
    tick(0, 0, 0, 0, 0);
    check("t1_out_valid_end", out_valid, 0);
    check("t1_free", free_count, 29);

    // drain free list, stall, then one retire frees a register
    for (int i = 0; i < 29; i++) tick(0, 1, 0, 0, 5'(i));
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 0, 0, 3);
      check("t2_stall_dec_ready", dec_ready, 0);
    end
    check("t2_free_zero", free_count, 0);
    tick(0, 0, 1, 7, 0);
    check("t2_stall", stall_cycles, 5);
    check("t2_no_early_retire", rn_retire_valid, 0);
    tick(0, 0, 0, 0, 0);
    check("t2_retire_forced", rn_retire_valid, 1);
    check("t2_retire_tag", rn_retire_phys_reg, 7);
    tick(0, 1, 0, 0, 9);
    check("t2_ret_done", ret_done_valid, 1);
    check("t2_ret_arch", ret_done_arch_reg, 24);
    check("t2_free_one", free_count, 1);
    check("t2_issue_after", dec_ready, 1);
    tick(0, 0, 0, 0, 0);
    check("t2_free_back", free_count, 0);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_phys_rd", out_phys_rd, 41);
    check("t2_stall_hold", stall_cycles, 5);

    // alternation after reset
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 1, 3, 1);
    check("t3_c0_issue", dec_ready, 1);
    check("t3_c0_noret", rn_retire_valid, 0);
    tick(0, 1, 1, 4, 1);
    check("t3_c1_noissue", dec_ready, 0);
    check("t3_c1_retire", rn_retire_valid, 1);
    check("t3_c1_tag", rn_retire_phys_reg, 3);
    tick(0, 1, 0, 0, 1);
    check("t3_c2_issue", dec_ready, 1);
    check("t3_c2_done", ret_done_valid, 1);
    check("t3_c2_arch", ret_done_arch_reg, 28);
    tick(0, 1, 0, 0, 1);
    check("t3_c3_retire", rn_retire_valid, 1);
    check("t3_c3_tag", rn_retire_phys_reg, 4);
    tick(0, 1, 0, 0, 1);
    check("t3_c4_issue", dec_ready, 1);
    tick(0, 0, 0, 0, 0);
    check("t3_free", free_count, 31);

    // fill the FIFO under alternation, forced retire, then overflow
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      tick(0, t4_dv[i][0], t4_rv[i][0], 6'(t4_tag[i]), 2);
      check($sformatf("t4_c%0d_issue", i), dec_ready, t4_gnt[i] == 1);
      check($sformatf("t4_c%0d_retire", i), rn_retire_valid, t4_gnt[i] == 2);
      check($sformatf("t4_c%0d_ready", i), ret_ready, t4_rdy[i]);
      check($sformatf("t4_c%0d_head", i), rn_retire_phys_reg, t4_head[i]);
      if (i == 10) check("t4_err_before", err_overflow, 0);
    end
    check("t4_last_arch", ret_done_arch_reg, 15);
    check("t4_err_set", err_overflow, 1);
    check("t4_free_sat", free_count, 32);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0);
    check("t4_err_sticky", err_overflow, 1);
    check("t4_free_hold", free_count, 32);

    // reset with 3 queued tags and free_count=20
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) tick(0, 1, 0, 0, 4);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 6'(i + 1), 4);
    tick(1, 1, 0, 0, 4);
    check("t6_free_pre", free_count, 20);
    check("t6_rst_dec_ready", dec_ready, 0);
    check("t6_rst_retire", rn_retire_valid, 0);
    tick(0, 0, 0, 0, 0);
    check("t6_free", free_count, 32);
    check("t6_out_valid", out_valid, 0);
    check("t6_ret_done", ret_done_valid, 0);
    check("t6_err", err_overflow, 0);
    check("t6_stall", stall_cycles, 0);
    check("t6_ready", ret_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0);
      check("t6_no_retire", rn_retire_valid, 0);
      check("t6_no_done", ret_done_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
